// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the CPU's single memory port between instruction
// fetch (requester 0) and data access (requester 1). Round-robin grant, one
// latched transaction at a time, registered done/err pulses and an ACCESS
// timeout so that a hung memory cannot stall the core forever.

// 32-bit 2:1 address mux; sel=0 picks input a.
module mem_port_mux2 (
    input  logic        i_sel,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_y
);
    assign o_y = i_sel ? i_b : i_a;
endmodule

module mem_port_arbiter #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0,
    input  logic [31:0] i_addr0,
    input  logic        i_req1,
    input  logic [31:0] i_addr1,
    input  logic        i_we1,
    input  logic [31:0] i_wdata1,
    input  logic        i_mem_ready,
    input  logic [31:0] i_mem_rdata,
    output logic        o_sel,
    output logic        o_mem_en,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [31:0] o_rdata,
    output logic        o_done0,
    output logic        o_done1,
    output logic        o_err,
    output logic        o_busy
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]    r_state;
    logic          r_sel;
    logic          r_last_grant;
    logic          r_mem_en;
    logic          r_mem_we;
    logic          r_done0;
    logic          r_done1;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [31:0]   r_addr0_q;
    logic [31:0]   r_addr1_q;
    logic [31:0]   r_wdata_q;
    logic          r_we_q;
    logic [TW-1:0] r_timer;

    logic          w_grant_vld;
    logic          w_grant;
    logic          w_timeout;

    // Round-robin pick: under contention the requester that did not win last
    // time gets the port; a lone requester always wins.
    assign w_grant_vld = i_req0 | i_req1;
    assign w_grant     = (i_req0 & i_req1) ? ~r_last_grant : i_req1;
    assign w_timeout   = (r_timer == T_LAST);

    // Transaction sequencer: IDLE grants and latches, ACCESS waits for the
    // memory (or the timer), DONE presents the one-cycle completion pulse.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_sel        <= 1'b0;
            r_last_grant <= 1'b1;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= 32'd0;
            r_addr0_q    <= 32'd0;
            r_addr1_q    <= 32'd0;
            r_wdata_q    <= 32'd0;
            r_we_q       <= 1'b0;
            r_timer      <= '0;
        end else begin
            // completion flags are pulses; only the ACCESS exit sets them
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_vld) begin
                        r_sel        <= w_grant;
                        r_last_grant <= w_grant;
                        r_addr0_q    <= i_addr0;
                        r_addr1_q    <= i_addr1;
                        r_wdata_q    <= i_wdata1;
                        r_we_q       <= w_grant & i_we1;
                        r_timer      <= '0;
                        r_mem_en     <= 1'b1;
                        r_mem_we     <= w_grant & i_we1;
                        r_state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_timer <= r_timer + TW'(1);
                    // success takes priority over a coincident timeout
                    if (i_mem_ready) begin
                        if (!r_we_q)
                            r_rdata <= i_mem_rdata;
                        r_done0  <= ~r_sel;
                        r_done1  <= r_sel;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        r_done0  <= ~r_sel;
                        r_done1  <= r_sel;
                        r_err    <= 1'b1;
                        r_mem_en <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    mem_port_mux2 u_addr_mux (
        .i_sel (r_sel),
        .i_a   (r_addr0_q),
        .i_b   (r_addr1_q),
        .o_y   (o_mem_addr)
    );

    assign o_sel       = r_sel;
    assign o_mem_en    = r_mem_en;
    assign o_mem_we    = r_mem_we;
    assign o_mem_wdata = r_wdata_q;
    assign o_rdata     = r_rdata;
    assign o_done0     = r_done0;
    assign o_done1     = r_done1;
    assign o_err       = r_err;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the multi-cycle CPU between instruction fetch (requester 0, PC address) and data access (requester 1, ALU-computed address).
- Arbitrates round-robin, latches the winner's address, write data and write enable, and sequences one memory transaction.
- Drives the select of the 32-bit 2:1 address mux (instantiated internally; sel=0 chooses requester 0).
- Returns read data with a one-cycle done pulse; a timeout guards against a hung memory.

Parameters:
TIMEOUT, 15, maximum ACCESS cycles without mem_ready before abort; range 1..255; timer width clog2(TIMEOUT+1)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
req0  in  1  fetch request, level, held until done0
addr0  in  32  fetch address
req1  in  1  data request, level, held until done1
addr1  in  32  data address
we1  in  1  data write enable (requester 0 is read-only)
wdata1  in  32  data write value
mem_ready  in  1  memory completes current access this cycle
mem_rdata  in  32  memory read data, valid with mem_ready
sel  out  1  address mux select / current owner
mem_en  out  1  memory access strobe
mem_we  out  1  memory write strobe
mem_addr  out  32  mux output: sel ? addr1_q : addr0_q
mem_wdata  out  32  latched wdata1
rdata  out  32  last captured read data
done0  out  1  one-cycle completion pulse for requester 0
done1  out  1  one-cycle completion pulse for requester 1
err  out  1  one-cycle, coincident with done: access timed out
busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n=0 at edge): state=IDLE, sel=0, mem_en=0, mem_we=0, done0=done1=0, err=0, rdata=0, addr0_q=addr1_q=wdata_q=0, we_q=0, timer=0, last_grant=1.
- All outputs registered except mem_addr (mux output of registered values).
- States: IDLE, ACCESS, DONE.
- IDLE:
  - no request: stay.
  - only one req: grant it.
  - both reqs: grant the one != last_grant.
  - On grant: latch sel=g, last_grant=g, addr0_q/addr1_q, we_q=(g==1)&we1, wdata_q=wdata1, timer=0.
  - Next state ACCESS, with mem_en=1 and mem_we=we_q in the following cycle.
- ACCESS:
  - mem_en=1 and mem_we held; timer increments each cycle.
  - mem_ready=1: rdata<=mem_rdata on reads only (unchanged on writes); done_g=1 next cycle; mem_en=mem_we=0; go DONE.
  - timer==TIMEOUT-1 without mem_ready: done_g=1 and err=1 next cycle; rdata unchanged; mem_en=mem_we=0; go DONE.
  - mem_ready and timeout in the same cycle: success wins, err=0.
- DONE: done_g/err high for this single cycle, then IDLE. Reqs are ignored in DONE; the requester deasserts req on seeing done.
- Latency: req sampled in IDLE at cycle t -> mem_en at t+1 -> if mem_ready at t+1, done at t+2.
- Minimum 3 cycles per transaction; back-to-back alternates under contention.
- Requester inputs are ignored outside IDLE; changing addr/wdata after grant has no effect.
- Req dropped mid-ACCESS: the transaction still completes and done still pulses.
- mem_ready outside ACCESS: ignored, no state change.
- sel holds its last value through DONE and IDLE until the next grant.
- Reset mid-ACCESS or mid-DONE: transaction discarded, no done pulse, all reset values next edge; last_grant=1 so the first contended grant goes to req0.

Test Plan:
1. Single read: req0=1, addr0=0x00000040 at t; mem_ready=1, mem_rdata=0xDEADBEEF at t+1 -> t+1 sel=0, mem_en=1, mem_addr=0x40; t+2 done0=1, rdata=0xDEADBEEF, err=0; t+3 busy=0.
2. Contention: req0=req1=1 held after reset, mem_ready always 1 -> grants 0,1,0,1; sel toggles; mem_addr alternates addr0/addr1; done pulses every 3 cycles.
3. Write: req1=1, we1=1, addr1=0x00000100, wdata1=0x12345678 -> sel=1, mem_we=1, mem_wdata=0x12345678, mem_addr=0x100; done1 pulses; rdata unchanged.
4. Timeout: req0 granted, mem_ready held 0 (TIMEOUT=15) -> mem_en high exactly 15 cycles, then done0=1 and err=1 for one cycle; rdata unchanged; IDLE after.
5. Reset mid-ACCESS: rst_n=0 for one edge during ACCESS of req1 -> next cycle mem_en=0, no done1, busy=0; then req0=req1=1 -> req0 granted first.
6. Stray/late inputs: mem_ready=1 pulsed in IDLE -> no state change; addr1 changed after grant -> mem_addr keeps the latched value.
